// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use bubbles, mispredict flushes and data-memory wait freezes,
// plus saturating stall/flush counters and a sticky memory-timeout flag.
module hazard_stall_controller #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_mispredict,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              stall_mux_sel,
  output logic              exmem_en,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              mem_timeout_err
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax = '1;

  localparam logic StRun     = 1'b0;
  localparam logic StMemWait = 1'b1;

  logic             state_q, state_d;
  logic [WaitW-1:0] wait_ctr_q, wait_ctr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             err_q, err_d;

  logic load_use;
  logic mem_wait;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign mem_wait = dmem_req && !dmem_ready;

  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    exmem_en      = 1'b1;
    ifid_flush    = 1'b0;
    stall_mux_sel = 1'b0;
    // Held in reset the pipe must free-run regardless of hazard inputs.
    if (rst_n) begin
      if (mem_wait) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        exmem_en = 1'b0;
      end else if (ex_mispredict) begin
        ifid_flush    = 1'b1;
        stall_mux_sel = 1'b1;
      end else if (load_use) begin
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        stall_mux_sel = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_ctr_d = wait_ctr_q;
    unique case (state_q)
      StRun: begin
        wait_ctr_d = '0;
        if (mem_wait) state_d = StMemWait;
      end
      StMemWait: begin
        if (dmem_ready) begin
          state_d = StRun;
        end else if (wait_ctr_q != WaitMax) begin
          wait_ctr_d = wait_ctr_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    err_d       = err_q || (wait_ctr_d == WaitMax);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ifid_flush && (flush_cnt_q != CntMax)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_ctr_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_ctr_q  <= wait_ctr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;
  assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: hazards, priority, memory wait/timeout, reset and
// counter saturation (second instance with 4-bit counters).
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_mispredict, dmem_req, dmem_ready;

  logic        pc_en, ifid_en, ifid_flush, stall_mux_sel, exmem_en, mem_timeout_err;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_en4, ifid_en4, ifid_flush4, stall_mux_sel4, exmem_en4, mem_timeout_err4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_stall_controller dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_mispredict(ex_mispredict), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .stall_mux_sel(stall_mux_sel), .exmem_en(exmem_en), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .mem_timeout_err(mem_timeout_err)
  );

  hazard_stall_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_mispredict(ex_mispredict), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4),
    .stall_mux_sel(stall_mux_sel4), .exmem_en(exmem_en4), .stall_cnt(stall_cnt4),
    .flush_cnt(flush_cnt4), .mem_timeout_err(mem_timeout_err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed as {pc_en, ifid_en, exmem_en, ifid_flush, stall_mux_sel}.
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, pc_en, ifid_en, exmem_en, ifid_flush, stall_mux_sel}, {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0; ex_mispredict = 0;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_load_use();
    ex_is_load = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    // Reset values hold even with a load-use hazard presented.
    set_load_use();
    #1;
    check_ctl("reset_outputs", 5'b11100);
    check("reset_stall_cnt", {16'd0, stall_cnt}, 0);
    check("reset_err", {31'd0, mem_timeout_err}, 0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    // T1 load-use through rs1, then rs2 path as a second pattern
    set_load_use();
    #1;
    check_ctl("t1_bubble", 5'b00101);
    tick();
    idle_inputs();
    #1;
    check_ctl("t1_run", 5'b11100);
    check("t1_stall_cnt", {16'd0, stall_cnt}, 1);
    ex_is_load = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1; id_rs1 = 5'd9;
    #1;
    check_ctl("t1_rs2_bubble", 5'b00101);
    id_uses_rs2 = 0;
    #1;
    check_ctl("t1_rs_unused", 5'b11100);
    idle_inputs();

    // T2 x0 never hazards
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    #1;
    check_ctl("t2_x0", 5'b11100);
    tick();
    check("t2_stall_cnt", {16'd0, stall_cnt}, 1);
    idle_inputs();

    // T3 mispredict wins over load-use
    pulse_reset();
    set_load_use();
    ex_mispredict = 1;
    #1;
    check_ctl("t3_flush", 5'b11111);
    tick();
    idle_inputs();
    check("t3_flush_cnt", {16'd0, flush_cnt}, 1);
    check("t3_stall_cnt", {16'd0, stall_cnt}, 0);

    // dmem_ready without a request is ignored
    dmem_ready = 1;
    #1;
    check_ctl("ready_no_req", 5'b11100);
    dmem_ready = 0;

    // T4 three wait cycles; mem_wait beats a mispredict too
    pulse_reset();
    dmem_req = 1; dmem_ready = 0; ex_mispredict = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ctl($sformatf("t4_freeze%0d", i), 5'b00000);
      tick();
    end
    ex_mispredict = 0;
    dmem_ready = 1;
    #1;
    check_ctl("t4_ready", 5'b11100);
    tick();
    idle_inputs();
    check("t4_stall_cnt", {16'd0, stall_cnt}, 3);
    check("t4_flush_cnt", {16'd0, flush_cnt}, 0);

    // T5 timeout: 70 consecutive wait cycles
    pulse_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 63) check("t5_err_early", {31'd0, mem_timeout_err}, 0);
      if (i == 66) check("t5_err_set", {31'd0, mem_timeout_err}, 1);
    end
    check_ctl("t5_still_frozen", 5'b00000);
    dmem_ready = 1;
    tick();
    idle_inputs();
    tick();
    check("t5_err_sticky", {31'd0, mem_timeout_err}, 1);
    check("t5_stall_cnt", {16'd0, stall_cnt}, 70);

    // T6 reset mid-wait
    dmem_req = 1; dmem_ready = 0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_ctl("t6_async_outputs", 5'b11100);
    check("t6_stall_cnt", {16'd0, stall_cnt}, 0);
    check("t6_err", {31'd0, mem_timeout_err}, 0);
    rst_n = 1'b1;
    idle_inputs();
    // A state stuck in MEM_WAIT would count these idle cycles into a timeout.
    for (int i = 0; i < 70; i++) tick();
    check("t6_state_run", {31'd0, mem_timeout_err}, 0);
    check("t6_idle_stall", {16'd0, stall_cnt}, 0);

    // Saturation: 20 stalls then 20 flushes
    set_load_use();
    for (int i = 0; i < 20; i++) tick();
    idle_inputs();
    check("sat_stall_w16", {16'd0, stall_cnt}, 20);
    check("sat_stall_w4", {28'd0, stall_cnt4}, 15);
    ex_mispredict = 1;
    for (int i = 0; i < 20; i++) tick();
    idle_inputs();
    check("sat_flush_w16", {16'd0, flush_cnt}, 20);
    check("sat_flush_w4", {28'd0, flush_cnt4}, 15);
    check("sat_stall_held", {28'd0, stall_cnt4}, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
